// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the 16-bit processor front end: opcodes and field layout.
// Pure constants; no logic, no latency.
// No flow control; consumers import what they need.
package instruction_fetch_pkg;

  // Field layout of an instruction word: opcode in the top bits, operand below.
  localparam int ADDR_W_DEF  = 10;
  localparam int INSTR_W_DEF = 16;
  localparam int OPC_W       = INSTR_W_DEF - ADDR_W_DEF;

  // Opcodes used by the fetch stage and by downstream decode.
  localparam logic [OPC_W-1:0] OP_NOP = 6'h00;
  localparam logic [OPC_W-1:0] OP_LDB = 6'h02;
  localparam logic [OPC_W-1:0] OP_JMP = 6'h20;

  // Operand field of an instruction word (jump target / immediate address).
  function automatic logic [ADDR_W_DEF-1:0] operand_of(input logic [INSTR_W_DEF-1:0] w);
    return w[ADDR_W_DEF-1:0];
  endfunction

  // Opcode field of an instruction word.
  function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W_DEF-1:0] w);
    return w[INSTR_W_DEF-1:ADDR_W_DEF];
  endfunction

endpackage

// File: rtl/instruction_fetch_program_counter.sv
// Program counter with next-PC priority mux and in-stage JMP resolution.
// PC updates one edge after its inputs are sampled; ROM address is the register itself.
// Stall holds the PC; a branch redirect overrides stall.
module program_counter
  import instruction_fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iStall,
  input  logic               iBranchTaken,
  input  logic [ADDR_W-1:0]  iBranchTarget,
  input  logic [INSTR_W-1:0] iRomInstruction,
  output logic [ADDR_W-1:0]  oPc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic              is_jmp;

  // JMP is decoded straight off the asynchronous ROM so a jump costs no bubble.
  assign is_jmp = (iRomInstruction[INSTR_W-1:ADDR_W] == OP_JMP);

  // Next-PC priority: branch redirect, then stall, then JMP, then sequential (wraps).
  always_comb begin
    pc_d = pc_q + ADDR_W'(1);
    if (iBranchTaken) begin
      pc_d = iBranchTarget;
    end else if (iStall) begin
      pc_d = pc_q;
    end else if (is_jmp) begin
      pc_d = iRomInstruction[ADDR_W-1:0];
    end
  end

  // PC register; reset wins over every other input.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign oPc = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives ROM address from the PC and captures words into IF/ID.
// ROM[PC] appears in IF/ID one edge later; a redirect leaves exactly one flushed slot.
// iStall freezes PC, IF/ID and the fetch counter; iBranchTaken flushes IF/ID even under stall.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int CNT_W   = 16
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iStall,
  input  logic               iBranchTaken,
  input  logic [ADDR_W-1:0]  iBranchTarget,
  output logic [ADDR_W-1:0]  oRomAddress,
  input  logic [INSTR_W-1:0] iRomInstruction,
  output logic [INSTR_W-1:0] oInstruction,
  output logic [ADDR_W-1:0]  oPCPlus1,
  output logic               oValid,
  output logic [CNT_W-1:0]   oFetchCount
);

  localparam int OPW = INSTR_W - ADDR_W;

  // Bubble word inserted on reset and on redirect flush.
  localparam logic [INSTR_W-1:0] NOP_WORD = {OPW'(OP_NOP), {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pcp1_q;
  logic               valid_q;
  logic [CNT_W-1:0]   cnt_q;

  program_counter #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_pc (
    .Clock           (Clock),
    .Reset           (Reset),
    .iStall          (iStall),
    .iBranchTaken    (iBranchTaken),
    .iBranchTarget   (iBranchTarget),
    .iRomInstruction (iRomInstruction),
    .oPc             (pc)
  );

  // IF/ID register and fetch counter: reset, flush on redirect, hold on stall, else capture.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      instr_q <= NOP_WORD;
      pcp1_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else if (iBranchTaken) begin
      instr_q <= NOP_WORD;
      pcp1_q  <= '0;
      valid_q <= 1'b0;
    end else if (!iStall) begin
      instr_q <= iRomInstruction;
      pcp1_q  <= pc + ADDR_W'(1);
      valid_q <= 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign oRomAddress  = pc;
  assign oInstruction = instr_q;
  assign oPCPlus1     = pcp1_q;
  assign oValid       = valid_q;
  assign oFetchCount  = cnt_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural asynchronous ROM.
// Checks are taken 1 time unit after each rising edge.
// Stall and redirect are driven directly from the scenario tasks.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic        Clock;
  logic        Reset;
  logic        iStall;
  logic        iBranchTaken;
  logic [9:0]  iBranchTarget;
  logic [9:0]  oRomAddress;
  logic [15:0] iRomInstruction;
  logic [15:0] oInstruction;
  logic [9:0]  oPCPlus1;
  logic        oValid;
  logic [15:0] oFetchCount;

  logic [15:0] rom [1024];
  int compared;
  int mismatched;

  instruction_fetch #(.ADDR_W(10), .INSTR_W(16), .CNT_W(16)) dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .iStall          (iStall),
    .iBranchTaken    (iBranchTaken),
    .iBranchTarget   (iBranchTarget),
    .oRomAddress     (oRomAddress),
    .iRomInstruction (iRomInstruction),
    .oInstruction    (oInstruction),
    .oPCPlus1        (oPCPlus1),
    .oValid          (oValid),
    .oFetchCount     (oFetchCount)
  );

  assign iRomInstruction = rom[oRomAddress];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    // intentionally unused: comparisons are written inline per scenario
  endtask

  task automatic test_reset();
    Reset = 1'b1; iStall = 1'b0; iBranchTaken = 1'b0; iBranchTarget = 10'd0;
    step(); step();
    compared++; if (oRomAddress !== 10'd0) begin mismatched++; $display("FAIL reset_addr got %0d want 0", oRomAddress); end
    compared++; if (oValid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %0b want 0", oValid); end
    compared++; if (oInstruction !== {OP_NOP, 10'd0}) begin mismatched++; $display("FAIL reset_instr got %h want %h", oInstruction, {OP_NOP, 10'd0}); end
    compared++; if (oPCPlus1 !== 10'd0) begin mismatched++; $display("FAIL reset_pcp1 got %0d want 0", oPCPlus1); end
    compared++; if (oFetchCount !== 16'd0) begin mismatched++; $display("FAIL reset_cnt got %0d want 0", oFetchCount); end
  endtask

  task automatic test_sequential();
    logic [15:0] exp_i [3];
    exp_i[0] = {OP_NOP, 10'd0}; exp_i[1] = {OP_NOP, 10'd2}; exp_i[2] = {OP_NOP, 10'd16};
    Reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      compared++; if (oInstruction !== exp_i[k]) begin mismatched++; $display("FAIL seq_instr[%0d] got %h want %h", k, oInstruction, exp_i[k]); end
      compared++; if (oPCPlus1 !== 10'(k + 1)) begin mismatched++; $display("FAIL seq_pcp1[%0d] got %0d want %0d", k, oPCPlus1, k + 1); end
      compared++; if (oValid !== 1'b1) begin mismatched++; $display("FAIL seq_valid[%0d] got %0b want 1", k, oValid); end
      compared++; if (oFetchCount !== 16'(k + 1)) begin mismatched++; $display("FAIL seq_cnt[%0d] got %0d want %0d", k, oFetchCount, k + 1); end
    end
  endtask

  task automatic test_stall();
    step(); step();  // PC 3 -> 5, IF/ID holds ROM[4]
    compared++; if (oRomAddress !== 10'd5) begin mismatched++; $display("FAIL stall_pre_addr got %0d want 5", oRomAddress); end
    iStall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      compared++; if (oRomAddress !== 10'd5) begin mismatched++; $display("FAIL stall_addr[%0d] got %0d want 5", k, oRomAddress); end
      compared++; if (oInstruction !== {OP_NOP, 10'd4}) begin mismatched++; $display("FAIL stall_instr[%0d] got %h want %h", k, oInstruction, {OP_NOP, 10'd4}); end
      compared++; if (oPCPlus1 !== 10'd5) begin mismatched++; $display("FAIL stall_pcp1[%0d] got %0d want 5", k, oPCPlus1); end
      compared++; if (oFetchCount !== 16'd5) begin mismatched++; $display("FAIL stall_cnt[%0d] got %0d want 5", k, oFetchCount); end
    end
    iStall = 1'b0;
    step();
    compared++; if (oInstruction !== {OP_NOP, 10'd5}) begin mismatched++; $display("FAIL stall_resume_instr got %h want %h", oInstruction, {OP_NOP, 10'd5}); end
    compared++; if (oPCPlus1 !== 10'd6) begin mismatched++; $display("FAIL stall_resume_pcp1 got %0d want 6", oPCPlus1); end
    compared++; if (oFetchCount !== 16'd6) begin mismatched++; $display("FAIL stall_resume_cnt got %0d want 6", oFetchCount); end
  endtask

  task automatic test_jmp();
    iBranchTaken = 1'b1; iBranchTarget = 10'd12;
    step();
    iBranchTaken = 1'b0;
    compared++; if (oRomAddress !== 10'd12) begin mismatched++; $display("FAIL jmp_addr0 got %0d want 12", oRomAddress); end
    compared++; if (oValid !== 1'b0) begin mismatched++; $display("FAIL jmp_flush_valid got %0b want 0", oValid); end
    compared++; if (oFetchCount !== 16'd6) begin mismatched++; $display("FAIL jmp_flush_cnt got %0d want 6", oFetchCount); end
    step();
    compared++; if (oRomAddress !== 10'd1000) begin mismatched++; $display("FAIL jmp_addr1 got %0d want 1000", oRomAddress); end
    compared++; if (oInstruction !== {OP_JMP, 10'd1000}) begin mismatched++; $display("FAIL jmp_instr1 got %h want %h", oInstruction, {OP_JMP, 10'd1000}); end
    compared++; if (oValid !== 1'b1) begin mismatched++; $display("FAIL jmp_valid1 got %0b want 1", oValid); end
    compared++; if (oPCPlus1 !== 10'd13) begin mismatched++; $display("FAIL jmp_pcp1_1 got %0d want 13", oPCPlus1); end
    step();
    compared++; if (oRomAddress !== 10'd14) begin mismatched++; $display("FAIL jmp_addr2 got %0d want 14", oRomAddress); end
    compared++; if (oInstruction !== {OP_JMP, 10'd14}) begin mismatched++; $display("FAIL jmp_instr2 got %h want %h", oInstruction, {OP_JMP, 10'd14}); end
    compared++; if (oPCPlus1 !== 10'd1001) begin mismatched++; $display("FAIL jmp_pcp1_2 got %0d want 1001", oPCPlus1); end
    step();
    compared++; if (oRomAddress !== 10'd15) begin mismatched++; $display("FAIL jmp_addr3 got %0d want 15", oRomAddress); end
    compared++; if (oInstruction !== {OP_NOP, 10'd14}) begin mismatched++; $display("FAIL jmp_instr3 got %h want %h", oInstruction, {OP_NOP, 10'd14}); end
    compared++; if (oFetchCount !== 16'd9) begin mismatched++; $display("FAIL jmp_cnt got %0d want 9", oFetchCount); end
  endtask

  task automatic test_branch_vs_stall();
    iBranchTaken = 1'b1; iBranchTarget = 10'd9;
    step();
    iStall = 1'b1; iBranchTarget = 10'd16;
    step();
    iStall = 1'b0; iBranchTaken = 1'b0;
    compared++; if (oRomAddress !== 10'd16) begin mismatched++; $display("FAIL bvs_addr got %0d want 16", oRomAddress); end
    compared++; if (oValid !== 1'b0) begin mismatched++; $display("FAIL bvs_valid got %0b want 0", oValid); end
    compared++; if (oInstruction !== {OP_NOP, 10'd0}) begin mismatched++; $display("FAIL bvs_instr got %h want %h", oInstruction, {OP_NOP, 10'd0}); end
    compared++; if (oPCPlus1 !== 10'd0) begin mismatched++; $display("FAIL bvs_pcp1 got %0d want 0", oPCPlus1); end
    step();
    compared++; if (oInstruction !== {OP_LDB, 10'd0}) begin mismatched++; $display("FAIL bvs_next_instr got %h want %h", oInstruction, {OP_LDB, 10'd0}); end
    compared++; if (oValid !== 1'b1) begin mismatched++; $display("FAIL bvs_next_valid got %0b want 1", oValid); end
    compared++; if (oPCPlus1 !== 10'd17) begin mismatched++; $display("FAIL bvs_next_pcp1 got %0d want 17", oPCPlus1); end
    compared++; if (oFetchCount !== 16'd10) begin mismatched++; $display("FAIL bvs_cnt got %0d want 10", oFetchCount); end
  endtask

  task automatic test_wrap();
    iBranchTaken = 1'b1; iBranchTarget = 10'd1023;
    step();
    iBranchTaken = 1'b0;
    compared++; if (oRomAddress !== 10'd1023) begin mismatched++; $display("FAIL wrap_addr0 got %0d want 1023", oRomAddress); end
    step();
    compared++; if (oRomAddress !== 10'd0) begin mismatched++; $display("FAIL wrap_addr1 got %0d want 0", oRomAddress); end
    compared++; if (oPCPlus1 !== 10'd0) begin mismatched++; $display("FAIL wrap_pcp1 got %0d want 0", oPCPlus1); end
    compared++; if (oValid !== 1'b1) begin mismatched++; $display("FAIL wrap_valid got %0b want 1", oValid); end
    compared++; if (oInstruction !== {OP_NOP, 10'd0}) begin mismatched++; $display("FAIL wrap_instr got %h want %h", oInstruction, {OP_NOP, 10'd0}); end
  endtask

  task automatic test_self_jmp();
    iBranchTaken = 1'b1; iBranchTarget = 10'd20;
    step();
    iBranchTaken = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      compared++; if (oRomAddress !== 10'd20) begin mismatched++; $display("FAIL selfjmp_addr[%0d] got %0d want 20", k, oRomAddress); end
      compared++; if (oInstruction !== {OP_JMP, 10'd20}) begin mismatched++; $display("FAIL selfjmp_instr[%0d] got %h want %h", k, oInstruction, {OP_JMP, 10'd20}); end
      compared++; if (oPCPlus1 !== 10'd21) begin mismatched++; $display("FAIL selfjmp_pcp1[%0d] got %0d want 21", k, oPCPlus1); end
      compared++; if (oFetchCount !== 16'(12 + k)) begin mismatched++; $display("FAIL selfjmp_cnt[%0d] got %0d want %0d", k, oFetchCount, 12 + k); end
    end
  endtask

  task automatic test_reset_mid();
    iBranchTaken = 1'b1; iBranchTarget = 10'd700;
    step();
    compared++; if (oRomAddress !== 10'd700) begin mismatched++; $display("FAIL rmid_pre_addr got %0d want 700", oRomAddress); end
    Reset = 1'b1; iStall = 1'b1; iBranchTarget = 10'd50;
    step();
    Reset = 1'b0; iStall = 1'b0; iBranchTaken = 1'b0;
    compared++; if (oRomAddress !== 10'd0) begin mismatched++; $display("FAIL rmid_addr got %0d want 0", oRomAddress); end
    compared++; if (oValid !== 1'b0) begin mismatched++; $display("FAIL rmid_valid got %0b want 0", oValid); end
    compared++; if (oFetchCount !== 16'd0) begin mismatched++; $display("FAIL rmid_cnt got %0d want 0", oFetchCount); end
    step();
    compared++; if (oRomAddress !== 10'd1) begin mismatched++; $display("FAIL rmid_post_addr got %0d want 1", oRomAddress); end
    compared++; if (oInstruction !== {OP_NOP, 10'd0}) begin mismatched++; $display("FAIL rmid_post_instr got %h want %h", oInstruction, {OP_NOP, 10'd0}); end
    compared++; if (oFetchCount !== 16'd1) begin mismatched++; $display("FAIL rmid_post_cnt got %0d want 1", oFetchCount); end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    Reset = 1'b1; iStall = 1'b0; iBranchTaken = 1'b0; iBranchTarget = 10'd0;
    for (int i = 0; i < 1024; i++) rom[i] = {OP_NOP, 10'(i)};
    rom[0]    = {OP_NOP, 10'd0};
    rom[1]    = {OP_NOP, 10'd2};
    rom[2]    = {OP_NOP, 10'd16};
    rom[12]   = {OP_JMP, 10'd1000};
    rom[1000] = {OP_JMP, 10'd14};
    rom[16]   = {OP_LDB, 10'd0};
    rom[20]   = {OP_JMP, 10'd20};
    rom[1023] = {OP_NOP, 10'd0};

    test_reset();
    test_sequential();
    test_stall();
    test_jmp();
    test_branch_vs_stall();
    test_wrap();
    test_self_jmp();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
